vote_tally_accum: RTL and testbench

- Parametrised vote accumulator: one WIDTH-bit saturating counter per candidate, NUM_CAND candidates.
- Generalises the team's fixed 4-bit ripple adder into a registered, multi-channel, handshaked add-by-one datapath.
- Sits between the ballot input decoder (upstream) and the result display/readout logic (downstream).
- Supports a sequential clear sweep and a registered readback port.

---
 rtl/vote_tally_accum.sv | 243 ++++++++++++++++++++++++
 tb/tb_vote_tally_accum.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_accum.sv
// -----------------------------------------------------------------------------
// vote_tally_accum
//
// Multi-channel vote accumulator. Each of NUM_CAND candidates owns one
// WIDTH-bit saturating counter that is bumped by one for every accepted
// vote. A one-cycle clear_req pulse starts a sequential sweep that zeroes
// one counter per cycle, and a registered readback port returns the count
// of any selected candidate one cycle later.
//
// Optional build feature (macro VOTE_TALLY_TOTAL_EN):
//   defined   -> adds total_count, a saturating count of every accepted
//                legal vote (including votes to a saturated candidate),
//                zeroed by reset and on the first sweep cycle.
//   undefined -> total_count port and its logic are absent.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   vote_valid   in   vote request present
//   vote_idx     in   candidate receiving the vote (IDX_W bits)
//   vote_ready   out  block accepts a vote this cycle
//   clear_req    in   one-cycle pulse that starts the clear sweep
//   busy         out  clear sweep in progress
//   rd_idx       in   readback candidate select (IDX_W bits)
//   rd_count     out  registered count of rd_idx (0 for rd_idx >= NUM_CAND)
//   sat_flag     out  sticky: some vote hit a saturated counter
//   idx_err      out  sticky: a vote was accepted with vote_idx >= NUM_CAND
//   total_count  out  (VOTE_TALLY_TOTAL_EN only) total accepted legal votes
//   fsm_state    out  debug view of the control FSM (0 = IDLE, 1 = CLEAR)
//
// Handshake: a vote transfers on a rising edge where vote_valid and
// vote_ready are both high. vote_ready depends only on the registered FSM
// state, never combinationally on vote_valid, so the upstream may hold a
// vote for as long as it likes; it is consumed on the first ready edge.
// -----------------------------------------------------------------------------
module vote_tally_accum #(
    parameter int NUM_CAND = 4,
    parameter int WIDTH    = 8,
    parameter int IDX_W    = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   vote_valid,
    input  logic [IDX_W-1:0]       vote_idx,
    output logic                   vote_ready,
    input  logic                   clear_req,
    output logic                   busy,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [WIDTH-1:0]       rd_count,
    output logic                   sat_flag,
    output logic                   idx_err,
`ifdef VOTE_TALLY_TOTAL_EN
    output logic [WIDTH+IDX_W-1:0] total_count,
`endif
    output logic                   fsm_state
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CAND - 1);

    state_t               state;
    state_t               state_nxt;

    logic [WIDTH-1:0]     counts [NUM_CAND];
    logic [IDX_W-1:0]     clr_ptr;
    logic                 clr_last;

    logic [NUM_CAND-1:0]  vote_hit;
    logic [WIDTH-1:0]     vote_cur;
    logic [WIDTH-1:0]     rd_sel;
    logic                 vote_legal;
    logic                 vote_accept;
    logic                 vote_at_max;

    // ------------------------------------------------------------------
    // Control FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next-state logic
    // A clear_req seen while already sweeping is simply not looked at,
    // so the sweep never restarts.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clr_last) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Control FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        vote_ready = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE:  vote_ready = 1'b1;
            ST_CLEAR: busy       = 1'b1;
            default: begin
                vote_ready = 1'b0;
                busy       = 1'b0;
            end
        endcase
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Sweep pointer. Held at 0 while idle so the sweep always starts at
    // candidate 0; advances once per CLEAR cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_ptr <= '0;
        end else if (state == ST_CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
        end else begin
            clr_ptr <= '0;
        end
    end

    assign clr_last = (state == ST_CLEAR) && (clr_ptr == LAST_IDX);

    // ------------------------------------------------------------------
    // Index decode. Matching against each legal index (rather than
    // indexing the array directly) makes out-of-range indices fall out
    // naturally: no hit, so the vote is illegal and readback returns 0.
    // ------------------------------------------------------------------
    always_comb begin
        vote_hit = '0;
        vote_cur = '0;
        rd_sel   = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            if (vote_idx == IDX_W'(i)) begin
                vote_hit[i] = 1'b1;
                vote_cur    = counts[i];
            end
            if (rd_idx == IDX_W'(i)) begin
                rd_sel = counts[i];
            end
        end
    end

    assign vote_legal  = |vote_hit;
    assign vote_accept = vote_valid & vote_ready;
    assign vote_at_max = (vote_cur == CNT_MAX);

    // ------------------------------------------------------------------
    // Candidate counters. Sweep zeroing and vote increments never collide
    // because votes are only accepted while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                counts[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CAND; i++) begin
                if ((state == ST_CLEAR) && (clr_ptr == IDX_W'(i))) begin
                    counts[i] <= '0;
                end else if (vote_accept && vote_hit[i] && (counts[i] != CNT_MAX)) begin
                    counts[i] <= counts[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered readback: samples the pre-increment value of the edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else begin
            rd_count <= rd_sel;
        end
    end

    // ------------------------------------------------------------------
    // Sticky flags, dropped together on the last sweep cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (clr_last) begin
            sat_flag <= 1'b0;
        end else if (vote_accept && vote_legal && vote_at_max) begin
            sat_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_err <= 1'b0;
        end else if (clr_last) begin
            idx_err <= 1'b0;
        end else if (vote_accept && !vote_legal) begin
            idx_err <= 1'b1;
        end
    end

`ifdef VOTE_TALLY_TOTAL_EN
    // ------------------------------------------------------------------
    // Grand total of legal votes. Counts even when the candidate itself
    // is saturated; zeroed on the first sweep cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_count <= '0;
        end else if ((state == ST_CLEAR) && (clr_ptr == '0)) begin
            total_count <= '0;
        end else if (vote_accept && vote_legal && (total_count != '1)) begin
            total_count <= total_count + 1'b1;
        end
    end
`else
    // No grand-total counter in this build.
`endif

endmodule

// File: tb/tb_vote_tally_accum.sv
// -----------------------------------------------------------------------------
// tb_vote_tally_accum
//
// Directed and randomized bench for vote_tally_accum (NUM_CAND=4, WIDTH=4,
// IDX_W=3). A behavioural model applies the tally rules at each rising
// edge; a compare process checks every DUT output against it on each
// falling edge. Directed sections also pin hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_vote_tally_accum;

    localparam int NUM_CAND = 4;
    localparam int WIDTH    = 4;
    localparam int IDX_W    = 3;
    localparam int CNT_MAX  = (1 << WIDTH) - 1;
    localparam int TOT_MAX  = (1 << (WIDTH + IDX_W)) - 1;

    logic                   clk        = 1'b0;
    logic                   rst_n      = 1'b0;
    logic                   vote_valid = 1'b0;
    logic [IDX_W-1:0]       vote_idx   = '0;
    logic                   clear_req  = 1'b0;
    logic [IDX_W-1:0]       rd_idx     = '0;
    logic                   vote_ready;
    logic                   busy;
    logic [WIDTH-1:0]       rd_count;
    logic                   sat_flag;
    logic                   idx_err;
    logic                   fsm_state;
`ifdef VOTE_TALLY_TOTAL_EN
    logic [WIDTH+IDX_W-1:0] total_count;
`endif

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    vote_tally_accum #(
        .NUM_CAND (NUM_CAND),
        .WIDTH    (WIDTH),
        .IDX_W    (IDX_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vote_valid  (vote_valid),
        .vote_idx    (vote_idx),
        .vote_ready  (vote_ready),
        .clear_req   (clear_req),
        .busy        (busy),
        .rd_idx      (rd_idx),
        .rd_count    (rd_count),
        .sat_flag    (sat_flag),
        .idx_err     (idx_err),
`ifdef VOTE_TALLY_TOTAL_EN
        .total_count (total_count),
`endif
        .fsm_state   (fsm_state)
    );

    // ---------------------------------------------------------------
    // Clock
    // ---------------------------------------------------------------
    initial forever #5 clk = ~clk;

    // ---------------------------------------------------------------
    // Comparison helper
    // ---------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------------------------------------------------------
    // Behavioural model: plain integer tallies updated on each edge.
    // m_clr_left counts sweep cycles still to run (0 = idle).
    // ---------------------------------------------------------------
    int               m_cnt [NUM_CAND];
    bit               m_sat;
    bit               m_err;
    int               m_clr_left;
    int               m_clr_pos;
    int               m_total;
    int               m_vi;
    int               m_ri;
    logic [WIDTH-1:0] exp_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_sat      = 1'b0;
            m_err      = 1'b0;
            m_clr_left = 0;
            m_clr_pos  = 0;
            m_total    = 0;
            // An asynchronous reset also wipes a readback already in flight.
            foreach (exp_q[i]) exp_q[i] = '0;
            if (clk) exp_q.push_back('0);
        end else begin
            m_vi = int'(vote_idx);
            m_ri = int'(rd_idx);
            exp_q.push_back((m_ri < NUM_CAND) ? WIDTH'(m_cnt[m_ri]) : '0);
            if (m_clr_left == 0) begin
                if (vote_valid) begin
                    if (m_vi < NUM_CAND) begin
                        if (m_cnt[m_vi] == CNT_MAX) m_sat = 1'b1;
                        else m_cnt[m_vi] = m_cnt[m_vi] + 1;
                        if (m_total < TOT_MAX) m_total = m_total + 1;
                    end else begin
                        m_err = 1'b1;
                    end
                end
                if (clear_req) begin
                    m_clr_left = NUM_CAND;
                    m_clr_pos  = 0;
                end
            end else begin
                m_cnt[m_clr_pos] = 0;
                if (m_clr_pos == 0) m_total = 0;
                m_clr_pos  = m_clr_pos + 1;
                m_clr_left = m_clr_left - 1;
                if (m_clr_left == 0) begin
                    m_sat = 1'b0;
                    m_err = 1'b0;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Scoreboard / compare process
    // ---------------------------------------------------------------
    logic [WIDTH-1:0] sb_exp;
    bit               sb_have;

    always @(negedge clk) begin
        sb_have = (exp_q.size() > 0);
        sb_exp  = sb_have ? exp_q.pop_front() : '0;
        if (chk_en) begin
            if (sb_have) check("rd_count", 32'(rd_count), 32'(sb_exp));
            check("vote_ready", 32'(vote_ready), 32'(m_clr_left == 0));
            check("busy", 32'(busy), 32'(m_clr_left != 0));
            check("sat_flag", 32'(sat_flag), 32'(m_sat));
            check("idx_err", 32'(idx_err), 32'(m_err));
`ifdef VOTE_TALLY_TOTAL_EN
            check("total_count", 32'(total_count), 32'(m_total));
`endif
        end
    end

    // ---------------------------------------------------------------
    // Driver tasks (entered and left on a falling edge)
    // ---------------------------------------------------------------
    task automatic do_reset();
        rst_n      = 1'b0;
        vote_valid = 1'b0;
        clear_req  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic vote(input int idx);
        vote_valid = 1'b1;
        vote_idx   = IDX_W'(idx);
        @(negedge clk);
    endtask

    task automatic idle_drive();
        vote_valid = 1'b0;
        clear_req  = 1'b0;
    endtask

    task automatic read_expect(input string name, input int idx, input int exp);
        rd_idx = IDX_W'(idx);
        @(negedge clk);
        check(name, 32'(rd_count), 32'(exp));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        check("sweep_done", 32'(busy), 32'd0);
    endtask

    // ---------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------
    int busy_n;
    int ready_lo;

    initial begin
        do_reset();
        chk_en = 1'b1;
        @(negedge clk);

        // Reset defaults
        for (int i = 0; i < NUM_CAND; i++) read_expect("reset_rd", i, 0);
        check("reset_ready", 32'(vote_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_sat", 32'(sat_flag), 32'd0);
        check("reset_err", 32'(idx_err), 32'd0);

        // Back-to-back votes
        vote(2); vote(2); vote(2); vote(0);
        idle_drive();
        read_expect("votes_c2", 2, 3);
        read_expect("votes_c0", 0, 1);
        read_expect("votes_c1", 1, 0);

        // Saturation: 17 votes to candidate 1
        for (int i = 0; i < 17; i++) vote(1);
        idle_drive();
        read_expect("sat_c1", 1, 15);
        check("sat_flag_set", 32'(sat_flag), 32'd1);
        read_expect("sat_c2_kept", 2, 3);
        read_expect("sat_c0_kept", 0, 1);

        // Illegal index
        vote(7);
        idle_drive();
        check("idx_err_set", 32'(idx_err), 32'd1);
        read_expect("ill_c0", 0, 1);
        read_expect("ill_c1", 1, 15);
        read_expect("ill_c2", 2, 3);
        read_expect("ill_c3", 3, 0);

        // Clear sweep with a vote held throughout
        clear_req = 1'b1;
        @(negedge clk);
        clear_req  = 1'b0;
        vote_valid = 1'b1;
        vote_idx   = IDX_W'(2);
        busy_n     = 0;
        ready_lo   = 0;
        for (int i = 0; i < 12 && busy; i++) begin
            busy_n++;
            if (!vote_ready) ready_lo++;
            @(negedge clk);
        end
        check("sweep_busy_cycles", 32'(busy_n), 32'd4);
        check("sweep_ready_low", 32'(ready_lo), 32'd4);
        check("post_sweep_sat", 32'(sat_flag), 32'd0);
        check("post_sweep_err", 32'(idx_err), 32'd0);
        @(negedge clk);
        idle_drive();
        read_expect("sweep_c0", 0, 0);
        read_expect("sweep_c1", 1, 0);
        read_expect("sweep_c3", 3, 0);
        read_expect("held_vote_c2", 2, 1);

        // Simultaneous vote and clear
        vote(3); vote(3);
        vote_valid = 1'b1;
        vote_idx   = IDX_W'(3);
        clear_req  = 1'b1;
        @(negedge clk);
        idle_drive();
        wait_idle();
        read_expect("simul_c3", 3, 0);

        // Reset in the middle of a sweep
        vote(1);
        idle_drive();
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midsweep_busy", 32'(busy), 32'd0);
        check("midsweep_rd", 32'(rd_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_ready", 32'(vote_ready), 32'd1);

        // Five legal votes
        vote(0); vote(1); vote(2); vote(3); vote(0);
        idle_drive();
        read_expect("five_c0", 0, 2);
`ifdef VOTE_TALLY_TOTAL_EN
        check("total_five", 32'(total_count), 32'd5);
`endif

        // Randomized traffic, checked by the model every cycle
        for (int n = 0; n < 1500; n++) begin
            vote_valid = ($urandom_range(0, 9) < 7);
            vote_idx   = ($urandom_range(0, 19) != 0) ? IDX_W'($urandom_range(0, NUM_CAND - 1))
                                                      : IDX_W'($urandom_range(NUM_CAND, 7));
            clear_req  = ($urandom_range(0, 59) == 0);
            rd_idx     = IDX_W'($urandom_range(0, 7));
            @(negedge clk);
        end
        idle_drive();
        repeat (8) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
